// File: rtl/n1_pkg.sv
// Shared constants and loader state encoding for the serial program loader.
// Optional checksum support is enabled by defining PROG_LOADER_CSUM_EN.
package n1_pkg;
    localparam int RAM_WORDS = 127;
    localparam int ADDR_W    = $clog2(RAM_WORDS);

    typedef enum logic [2:0] {
        ST_LEN, ST_HI, ST_LO, ST_WRITE, ST_CSUM, ST_DONE, ST_ERR
    } ld_state_e;
endpackage

// File: rtl/n1_xor_acc.sv
// Byte-wide XOR accumulator with synchronous clear and enable.
// Used by prog_loader only when PROG_LOADER_CSUM_EN is defined.
module n1_xor_acc (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] din,
    output logic [7:0] acc
);
    always_ff @(posedge clk) begin
        if (rst || clr)
            acc <= 8'h00;
        else if (en)
            acc <= acc ^ din;
    end
endmodule

// File: rtl/prog_loader.sv
// Serial byte-stream program loader: LEN, N big-endian words, optional CSUM byte.
// Define PROG_LOADER_CSUM_EN to enable the trailing XOR checksum byte.
module prog_loader #(
    parameter int RAM_WORDS = n1_pkg::RAM_WORDS,
    parameter int ADDR_W    = $clog2(RAM_WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              err
);
    import n1_pkg::*;

    ld_state_e         state, state_nx;
    logic [ADDR_W-1:0] last_addr;
    logic [7:0]        hi_q, lo_q;
    logic              accept, len_bad, last_word;

    assign accept    = in_valid && in_ready;
    assign len_bad   = (in_data == 8'd0) || (32'(in_data) > RAM_WORDS);
    assign last_word = (mem_addr == last_addr);
    assign mem_wdata = {hi_q, lo_q};

`ifdef PROG_LOADER_CSUM_EN
    logic [7:0] csum_acc;
    logic       acc_clr, acc_en;

    assign acc_clr = (state == ST_LEN) && accept;
    assign acc_en  = ((state == ST_HI) || (state == ST_LO)) && accept;

    n1_xor_acc u_xor_acc (
        .clk (clk),
        .rst (rst),
        .clr (acc_clr),
        .en  (acc_en),
        .din (in_data),
        .acc (csum_acc)
    );
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_LEN;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        mem_we   = 1'b0;
        cpu_rst  = 1'b1;
        done     = 1'b0;
        err      = 1'b0;
        case (state)
            ST_LEN: begin
                in_ready = 1'b1;
                if (accept) state_nx = len_bad ? ST_ERR : ST_HI;
            end
            ST_HI: begin
                in_ready = 1'b1;
                if (accept) state_nx = ST_LO;
            end
            ST_LO: begin
                in_ready = 1'b1;
                if (accept) state_nx = ST_WRITE;
            end
            ST_WRITE: begin
                mem_we = 1'b1;
`ifdef PROG_LOADER_CSUM_EN
                state_nx = last_word ? ST_CSUM : ST_HI;
`else
                state_nx = last_word ? ST_DONE : ST_HI;
`endif
            end
`ifdef PROG_LOADER_CSUM_EN
            ST_CSUM: begin
                in_ready = 1'b1;
                if (accept) state_nx = (in_data == csum_acc) ? ST_DONE : ST_ERR;
            end
`endif
            ST_DONE: begin
                done    = 1'b1;
                cpu_rst = 1'b0;
            end
            ST_ERR: begin
                err = 1'b1;
            end
            default: state_nx = ST_LEN;
        endcase
    end

    // The address is held on the final write so it never points past the last valid word.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_addr  <= '0;
            last_addr <= '0;
            hi_q      <= 8'h00;
            lo_q      <= 8'h00;
        end else begin
            if (state == ST_LEN && accept) begin
                mem_addr  <= '0;
                last_addr <= ADDR_W'(in_data - 8'd1);
            end
            if (state == ST_HI && accept) hi_q <= in_data;
            if (state == ST_LO && accept) lo_q <= in_data;
            if (state == ST_WRITE && !last_word) mem_addr <= mem_addr + 1'b1;
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader; covers both PROG_LOADER_CSUM_EN builds.
module tb_prog_loader;
    localparam int RW = 127;
    localparam int AW = 7;
`ifdef PROG_LOADER_CSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    in_data = 8'h00;
    logic          in_valid = 1'b0;
    logic          in_ready, mem_we, cpu_rst, done, err;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_wdata;

    prog_loader #(.RAM_WORDS(RW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .cpu_rst(cpu_rst), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct { int addr; int data; } wr_t;
    wr_t         wr_q[$];
    int          rdy_bad = 0;
    int          chk_cnt = 0;
    int          pass_cnt = 0;
    logic [15:0] exp_w[0:127];

    // Observed RAM writes, captured mid-cycle
    always @(negedge clk) begin
        if (mem_we) begin
            wr_q.push_back('{int'(mem_addr), int'(mem_wdata)});
            if (in_ready) rdy_bad++;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; in_data = 8'h01;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        wr_q.delete();
        rdy_bad = 0;
    endtask

    // Present one byte after 'gap' idle cycles; returns just after the accepting edge
    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b1; in_data = b;
        t = 0;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk_cnt++;
        if (t >= 100) $display("FAIL send_byte timeout: in_ready=%b required 1 (byte %h)", in_ready, b);
        else pass_cnt++;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Sends LEN, exp_w[0..n-1], and the checksum (optionally corrupted)
    task automatic send_frame(input int n, input bit bad_csum, input int max_gap);
        logic [7:0] x;
        x = 8'h00;
        send_byte(8'(n), $urandom_range(max_gap));
        for (int i = 0; i < n; i++) begin
            send_byte(exp_w[i][15:8], $urandom_range(max_gap));
            send_byte(exp_w[i][7:0], $urandom_range(max_gap));
            x = x ^ exp_w[i][15:8] ^ exp_w[i][7:0];
        end
        if (CSUM_ON) send_byte(bad_csum ? (x ^ 8'h01) : x, $urandom_range(max_gap));
    endtask

    task automatic check_frame(input string tag, input int n, input bit bad_csum);
        bit ok_exp;
        ok_exp = !(CSUM_ON && bad_csum);
        repeat (3) @(negedge clk);
        chk_cnt++;
        if (wr_q.size() !== n) $display("FAIL %s write count: got %0d required %0d", tag, wr_q.size(), n);
        else pass_cnt++;
        for (int i = 0; i < n; i++) begin
            chk_cnt++;
            if (i >= wr_q.size()) $display("FAIL %s write %0d missing", tag, i);
            else if (wr_q[i].addr !== i || wr_q[i].data !== int'(exp_w[i]))
                $display("FAIL %s write %0d: got addr %0d data %h required addr %0d data %h",
                         tag, i, wr_q[i].addr, wr_q[i].data[15:0], i, exp_w[i]);
            else pass_cnt++;
        end
        chk_cnt++;
        if ({done, err, cpu_rst} !== {ok_exp, !ok_exp, !ok_exp})
            $display("FAIL %s status: got done/err/cpu_rst %b%b%b required %b%b%b",
                     tag, done, err, cpu_rst, ok_exp, !ok_exp, !ok_exp);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        chk_cnt++;
        if ({in_ready, mem_we, cpu_rst, done, err} !== 5'b10100 || mem_addr !== '0 || mem_wdata !== 16'h0)
            $display("FAIL reset: got rdy/we/cpu_rst/done/err %b%b%b%b%b addr %0d wdata %h required 10100 0 0000",
                     in_ready, mem_we, cpu_rst, done, err, mem_addr, mem_wdata);
        else pass_cnt++;
    endtask

    task automatic test_spec_frames();
`ifdef PROG_LOADER_CSUM_EN
        for (int k = 0; k < 2; k++) begin
            logic [7:0] cs;
            cs = (k == 0) ? 8'h40 : 8'h41;
            do_reset();
            exp_w[0] = 16'h1234; exp_w[1] = 16'hABCD;
            send_byte(8'h02, 0); send_byte(8'h12, 0); send_byte(8'h34, 0);
            send_byte(8'hAB, 0); send_byte(8'hCD, 0); send_byte(cs, 0);
            chk_cnt++;
            if (done !== (k == 0) || err !== (k == 1) || cpu_rst !== (k == 1))
                $display("FAIL csum_%0h cycle after accept: got done/err/cpu_rst %b%b%b required %b%b%b",
                         cs, done, err, cpu_rst, k == 0, k == 1, k == 1);
            else pass_cnt++;
            check_frame(k == 0 ? "csum_match" : "csum_mismatch", 2, k == 1);
        end
`else
        do_reset();
        exp_w[0] = 16'h0007;
        send_byte(8'h01, 0); send_byte(8'h00, 0); send_byte(8'h07, 0);
        @(negedge clk);
        chk_cnt++;
        if (mem_we !== 1'b1 || mem_addr !== '0 || mem_wdata !== 16'h0007 || done !== 1'b0)
            $display("FAIL nocsum write cycle: got we %b addr %0d data %h done %b required 1 0 0007 0",
                     mem_we, mem_addr, mem_wdata, done);
        else pass_cnt++;
        @(negedge clk);
        chk_cnt++;
        if (done !== 1'b1 || cpu_rst !== 1'b0)
            $display("FAIL nocsum done timing: got done %b cpu_rst %b required 1 0", done, cpu_rst);
        else pass_cnt++;
        check_frame("nocsum", 1, 1'b0);
`endif
    endtask

    task automatic test_bad_len();
        logic [7:0] lens[3];
        lens = '{8'h00, 8'h80, 8'hFF};
        foreach (lens[i]) begin
            do_reset();
            send_byte(lens[i], 0);
            chk_cnt++;
            if ({err, cpu_rst, done} !== 3'b110)
                $display("FAIL bad_len %h: got err/cpu_rst/done %b%b%b required 110", lens[i], err, cpu_rst, done);
            else pass_cnt++;
            @(negedge clk);
            in_valid = 1'b1;
            repeat (8) begin
                in_data = 8'($urandom);
                @(negedge clk);
            end
            chk_cnt++;
            if (in_ready !== 1'b0 || wr_q.size() !== 0 || err !== 1'b1)
                $display("FAIL bad_len %h hold: got rdy %b writes %0d err %b required 0 0 1",
                         lens[i], in_ready, wr_q.size(), err);
            else pass_cnt++;
            in_valid = 1'b0;
        end
    endtask

    task automatic test_random_gaps();
        do_reset();
        for (int i = 0; i < 3; i++) exp_w[i] = 16'($urandom);
        send_frame(3, 1'b0, 4);
        check_frame("gaps", 3, 1'b0);
        chk_cnt++;
        if (rdy_bad !== 0) $display("FAIL gaps in_ready during write: got %0d cycles required 0", rdy_bad);
        else pass_cnt++;
    endtask

    task automatic test_rst_mid_frame();
        do_reset();
        send_byte(8'h02, 0);
        send_byte(8'hAA, 0);
        do_reset();
        exp_w[0] = 16'hBEEF;
        send_frame(1, 1'b0, 0);
        check_frame("rst_mid", 1, 1'b0);
    endtask

    task automatic test_random_frames();
        for (int k = 0; k < 5; k++) begin
            int n;
            bit bad;
            n = $urandom_range(8, 1);
            bad = CSUM_ON ? 1'($urandom_range(1)) : 1'b0;
            do_reset();
            for (int i = 0; i < n; i++) exp_w[i] = 16'($urandom);
            send_frame(n, bad, 2);
            check_frame("random", n, bad);
        end
    endtask

    task automatic test_max_len();
        do_reset();
        for (int i = 0; i < RW; i++) exp_w[i] = 16'($urandom);
        send_frame(RW, 1'b0, 0);
        check_frame("max_len", RW, 1'b0);
    endtask

    initial begin
        test_reset();
        test_spec_frames();
        test_bad_len();
        test_random_gaps();
        test_rst_mid_frame();
        test_random_frames();
        test_max_len();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter RAM_WORDS, default 127, number of 16-bit program RAM words addressable.
REQ-002 Parameter ADDR_W, default 7, equals $clog2(RAM_WORDS), width of mem_addr.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_data  input  8  serial load byte.
REQ-006 in_valid  input  1  in_data valid.
REQ-007 in_ready  output  1  loader accepts byte this cycle.
REQ-008 mem_we  output  1  one-cycle program RAM write strobe.
REQ-009 mem_addr  output  ADDR_W  RAM write word address.
REQ-010 mem_wdata  output  16  RAM write word.
REQ-011 cpu_rst  output  1  held high to keep the core in reset until load completes.
REQ-012 done  output  1  load finished successfully (sticky).
REQ-013 err  output  1  load aborted (sticky).

Function
REQ-014 Byte accepted only when in_valid && in_ready are both high in the same cycle.
REQ-015 Frame: LEN byte (word count N), then N words of 2 bytes each (high byte first), then CSUM byte if enabled.
REQ-016 FSM states: LEN, HI, LO, WRITE, CSUM, DONE, ERR; reset state is LEN.
REQ-017 in_ready is high in LEN, HI, LO and CSUM; it is low in WRITE, DONE and ERR.
REQ-018 LEN: on accept, if N==0 or N>RAM_WORDS, go to ERR; else latch N, clear mem_addr, go to HI.
REQ-019 HI: on accept, latch high byte, go to LO; LO: on accept, latch low byte, go to WRITE.
REQ-020 WRITE: mem_we high for exactly this one cycle with mem_addr and mem_wdata stable.
REQ-021 WRITE exit: mem_addr increments by one; if N words written, go to CSUM (or DONE if disabled), else go to HI.
REQ-022 Per-word latency: 3 cycles minimum (HI accept, LO accept, WRITE); in_valid gaps stall without loss.
REQ-023 mem_addr never exceeds RAM_WORDS-1; no wrap-around occurs because N is range-checked.
REQ-024 DONE: done=1, cpu_rst=0; stays in DONE until rst.
REQ-025 ERR: err=1, cpu_rst=1; stays in ERR until rst; no further mem_we.
REQ-026 mem_we is 0 in every state except WRITE.

Reset
REQ-027 On rst: state=LEN, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rst=1, done=0, err=0, checksum accumulator=0.
REQ-028 rst mid-frame abandons the frame; words already written remain in RAM; the next byte accepted is treated as LEN.
REQ-029 If rst and in_valid are both high in the same cycle, no byte is consumed.

Configuration
REQ-030 Macro PROG_LOADER_CSUM_EN defined: XOR of all 2N data bytes is accumulated; the CSUM byte is compared to it; a match goes to DONE, a mismatch goes to ERR.
REQ-031 Macro PROG_LOADER_CSUM_EN undefined: no CSUM state or accumulator; go directly to DONE after the last WRITE.

Structure
REQ-032 Shared package n1_pkg holds RAM_WORDS, ADDR_W and the loader state enum typedef.
REQ-033 One sub-module, n1_xor_acc (byte XOR accumulator with clear and enable), is instantiated only under PROG_LOADER_CSUM_EN.

Verification
REQ-034 CSUM enabled; send 02,12,34,AB,CD,CSUM=40 -> writes addr0=1234, addr1=ABCD; done=1 and cpu_rst=0 one cycle after CSUM accept.
REQ-035 CSUM enabled; same frame with CSUM=41 -> both words written, then err=1, done=0, cpu_rst stays 1.
REQ-036 LEN=00 or LEN=80 (with RAM_WORDS=127) -> err=1 the cycle after accept; no mem_we ever.
REQ-037 Random in_valid gaps over an N=3 frame -> identical writes; in_ready=0 during every WRITE cycle.
REQ-038 rst pulsed after the HI byte of word 1; then send a new frame 01,BE,EF(,CSUM=51) -> addr0=BEEF, done=1.
REQ-039 CSUM undefined; frame 01,00,07 -> addr0=0007; done=1 the cycle after WRITE.
